divider: RTL and testbench
==========================

Name: divider

Overview:
- Iterative 32-bit integer divider that serves the EX stage's multi-cycle divide requests.
- It is the responder end of the EX start/end handshake: EX raises start with operands, then holds.
- The divider computes quotient and remainder by radix-2 restoring division and asserts end with stable results until EX/MEM accepts them.
- Instantiated inside EX next to the multiplier; EX selects quotient or remainder into its result.

Parameters:
DATA_W, 32, operand/result width; the iteration count equals DATA_W.

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-high
div_start_i  in  1  level request from EX (divide op & EX valid); operands valid while high
div_signed_i  in  1  1 = signed (two's complement), 0 = unsigned
div_opd1_i  in  DATA_W  dividend
div_opd2_i  in  DATA_W  divisor
div_accept_i  in  1  EX result consumed this cycle (EX over & downstream allow-in)
quotient_o  out  DATA_W  quotient, valid while div_end_o=1
remainder_o  out  DATA_W  remainder, valid while div_end_o=1
div_end_o  out  1  result ready; held until div_accept_i
div_busy_o  out  1  high in BUSY/FIX

Behaviour:
- Reset:
  - Asynchronous, active-high; effective at any time, including mid-division.
  - Forces state IDLE, counter 0, and all outputs 0 (quotient_o, remainder_o, div_end_o, div_busy_o).
  - Any in-flight operation is discarded; no end pulse follows.
- States: IDLE, BUSY, FIX, DONE.
- IDLE:
  - If div_start_i=1 at the clock edge, latch signedness, dividend sign, divisor sign and operand magnitudes.
  - A magnitude is |x| when signed, else x.
  - Clear the partial remainder, load the count DATA_W, go to BUSY. Otherwise stay in IDLE.
- BUSY, one iteration per cycle:
  - Shift {rem,quo} left by 1 and form trial = rem_shifted - divisor_mag (DATA_W+1 bits).
  - If trial is non-negative: rem = trial and quotient LSB = 1; else keep rem and quotient LSB = 0.
  - Decrement the count; after the DATA_W-th iteration go to FIX.
- FIX, one cycle:
  - Signed: negate the quotient if the operand signs differ; negate the remainder if the dividend is negative. The remainder sign always follows the dividend.
  - Unsigned: results pass through unchanged.
  - Register the results to quotient_o/remainder_o and go to DONE.
- DONE:
  - div_end_o=1; outputs are held stable.
  - On div_accept_i=1, go to IDLE and drop div_end_o on the next cycle.
  - div_start_i is ignored while in DONE.
- Latency: start sampled at edge k → div_end_o high from cycle k+DATA_W+2 (34 for DATA_W=32).
- Back-to-back:
  - If div_start_i is still high after accept, it is for the next instruction; it is sampled in IDLE one cycle later.
  - This gives one bubble cycle by design.
- div_start_i dropping during BUSY/FIX: the operation continues (EX cannot flush in this design); the result is delivered and awaits accept.
- Divide by zero:
  - The natural restoring result is taken: quotient = all ones, remainder = dividend.
  - In signed mode the FIX sign correction is bypassed for a zero divisor, so the result is exactly q=0xFFFFFFFF, r=opd1.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives q=0x80000000 (wraps), r=0. No flag is raised.
- Width rules:
  - Magnitudes are DATA_W bits unsigned; |0x80000000| = 0x80000000 is representable.
  - The trial subtraction is DATA_W+1 bits.
- div_busy_o is 1 in BUSY and FIX only.

Decomposition:
- Shared header (common.vh):
  - state width and encodings: DivIdle, DivBusy, DivFix, DivDone;
  - `DivCntW = 6;
  - the result-select op encodings EX uses to choose quotient or remainder.
- One natural sub-module: div_step, a combinational single restoring step (shift, trial subtract, select).
  - Instantiated once in divider; it is reusable if a radix-4 variant is needed later.

Test Plan:
1. Unsigned 100/7, start held one cycle from edge k → div_end_o rises at k+34; q=14, r=2; outputs hold until accept.
2. Signed basic sign cases:
   - 0xFFFFFFF9 (−7) / 2 → q=0xFFFFFFFD, r=0xFFFFFFFF.
   - 7 / 0xFFFFFFFE → q=0xFFFFFFFD, r=1.
3. Signed 0x80000000 / 0xFFFFFFFF → q=0x80000000, r=0. The same operands unsigned → q=0, r=0x80000000.
4. Divide by zero with opd1=0x12345678, signed and unsigned → q=0xFFFFFFFF, r=0x12345678; end at the normal latency.
5. Assert rst_i asynchronously 10 cycles after start, between clock edges → outputs 0 immediately; no div_end_o. A fresh 9/3 after release → q=3, r=0.
6. Back-to-back, with div_start_i held high across accept and new operands 50/5 presented after accept:
   - the first result stays stable while accept=0 for 5 cycles;
   - the second op starts one cycle after accept and gives q=10, r=0 at accept+1+34.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared types and constants for the iterative restoring divider.
package divider_pkg;

    localparam int unsigned DIV_DATA_W = 32;
    localparam int unsigned DIV_CNT_W  = 6;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_FIX  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_e;

    // EX uses this to pick quotient or remainder into its result bus
    typedef enum logic {
        DIV_SEL_QUO = 1'b0,
        DIV_SEL_REM = 1'b1
    } div_sel_e;

endpackage

// File: rtl/divider_div_step.sv
// One radix-2 restoring step: shift {rem,quo} left, trial-subtract, select.
module divider_div_step
    import divider_pkg::*;
#(
    parameter int unsigned DATA_W = DIV_DATA_W
) (
    input  logic [DATA_W-1:0] rem_i,
    input  logic [DATA_W-1:0] quo_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [DATA_W-1:0] rem_o,
    output logic [DATA_W-1:0] quo_o
);

    logic [DATA_W:0] shifted;
    logic [DATA_W:0] trial;

    always_comb begin
        shifted = {rem_i, quo_i[DATA_W-1]};
        trial   = shifted - {1'b0, divisor_i};
        // a set MSB means the trial went negative: restore
        rem_o   = trial[DATA_W] ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
        quo_o   = {quo_i[DATA_W-2:0], ~trial[DATA_W]};
    end

endmodule

// File: rtl/divider.sv
// Multi-cycle signed/unsigned 32-bit divider answering EX's start/end handshake.
module divider
    import divider_pkg::*;
#(
    parameter int unsigned DATA_W = DIV_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              div_start_i,
    input  logic              div_signed_i,
    input  logic [DATA_W-1:0] div_opd1_i,
    input  logic [DATA_W-1:0] div_opd2_i,
    input  logic              div_accept_i,
    output logic [DATA_W-1:0] quotient_o,
    output logic [DATA_W-1:0] remainder_o,
    output logic              div_end_o,
    output logic              div_busy_o
);

    div_state_e           state_q, state_d;
    logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
    logic                 neg1_q, neg1_d;
    logic                 neg2_q, neg2_d;
    logic [DATA_W-1:0]    rem_q, rem_d;
    logic [DATA_W-1:0]    quo_q, quo_d;
    logic [DATA_W-1:0]    dvs_q, dvs_d;
    logic [DATA_W-1:0]    quotient_d, remainder_d;
    logic                 end_d, busy_d;
    logic [DATA_W-1:0]    step_rem, step_quo;

    divider_div_step #(.DATA_W(DATA_W)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= DIV_IDLE;
            cnt_q       <= '0;
            neg1_q      <= 1'b0;
            neg2_q      <= 1'b0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            quotient_o  <= '0;
            remainder_o <= '0;
            div_end_o   <= 1'b0;
            div_busy_o  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            neg1_q      <= neg1_d;
            neg2_q      <= neg2_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            quotient_o  <= quotient_d;
            remainder_o <= remainder_d;
            div_end_o   <= end_d;
            div_busy_o  <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        neg1_d      = neg1_q;
        neg2_d      = neg2_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        quotient_d  = quotient_o;
        remainder_d = remainder_o;

        unique case (state_q)
            DIV_IDLE: begin
                if (div_start_i) begin
                    // sign flags are only ever set in signed mode
                    neg1_d  = div_signed_i & div_opd1_i[DATA_W-1];
                    neg2_d  = div_signed_i & div_opd2_i[DATA_W-1];
                    quo_d   = neg1_d ? -div_opd1_i : div_opd1_i;
                    dvs_d   = neg2_d ? -div_opd2_i : div_opd2_i;
                    rem_d   = '0;
                    cnt_d   = DIV_CNT_W'(DATA_W);
                    state_d = DIV_BUSY;
                end
            end
            DIV_BUSY: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q - DIV_CNT_W'(1);
                if (cnt_q == DIV_CNT_W'(1)) begin
                    state_d = DIV_FIX;
                end
            end
            DIV_FIX: begin
                // a zero divisor keeps the raw all-ones quotient
                quotient_d  = ((neg1_q ^ neg2_q) && (dvs_q != '0)) ? -quo_q : quo_q;
                remainder_d = neg1_q ? -rem_q : rem_q;
                state_d     = DIV_DONE;
            end
            DIV_DONE: begin
                if (div_accept_i) begin
                    state_d = DIV_IDLE;
                end
            end
            default: state_d = DIV_IDLE;
        endcase

        end_d  = (state_d == DIV_DONE);
        busy_d = (state_d == DIV_BUSY) || (state_d == DIV_FIX);
    end

endmodule

// File: tb/tb_divider.sv
// Directed bench for the divider: latency, sign handling, corner cases, reset, back-to-back.
module tb_divider;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        div_start_i;
    logic        div_signed_i;
    logic [31:0] div_opd1_i;
    logic [31:0] div_opd2_i;
    logic        div_accept_i;
    logic [31:0] quotient_o;
    logic [31:0] remainder_o;
    logic        div_end_o;
    logic        div_busy_o;

    int n_vec = 0;
    int n_err = 0;
    logic end_seen;

    divider u_dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .div_start_i  (div_start_i),
        .div_signed_i (div_signed_i),
        .div_opd1_i   (div_opd1_i),
        .div_opd2_i   (div_opd2_i),
        .div_accept_i (div_accept_i),
        .quotient_o   (quotient_o),
        .remainder_o  (remainder_o),
        .div_end_o    (div_end_o),
        .div_busy_o   (div_busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present operands, let the edge sample start, optionally keep start high.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                            input logic hold);
        div_opd1_i   = a;
        div_opd2_i   = b;
        div_signed_i = sgn;
        div_start_i  = 1'b1;
        @(posedge clk_i);
        #1;
        div_start_i = hold;
    endtask

    // Called 1 time unit after the start edge k; end must appear after edge k+33.
    task automatic wait_result(input string tag, input logic [31:0] eq, input logic [31:0] er);
        repeat (32) @(posedge clk_i);
        #1;
        check({tag, "_end_early"}, 32'(div_end_o), 32'd0);
        check({tag, "_busy_fix"},  32'(div_busy_o), 32'd1);
        @(posedge clk_i);
        #1;
        check({tag, "_end"},  32'(div_end_o), 32'd1);
        check({tag, "_busy"}, 32'(div_busy_o), 32'd0);
        check({tag, "_q"}, quotient_o, eq);
        check({tag, "_r"}, remainder_o, er);
    endtask

    task automatic do_accept(input string tag);
        div_accept_i = 1'b1;
        @(posedge clk_i);
        #1;
        div_accept_i = 1'b0;
        check({tag, "_end_drop"}, 32'(div_end_o), 32'd0);
    endtask

    initial begin
        rst_i        = 1'b1;
        div_start_i  = 1'b0;
        div_signed_i = 1'b0;
        div_opd1_i   = '0;
        div_opd2_i   = '0;
        div_accept_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_q",    quotient_o, 32'd0);
        check("rst_r",    remainder_o, 32'd0);
        check("rst_end",  32'(div_end_o), 32'd0);
        check("rst_busy", 32'(div_busy_o), 32'd0);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // unsigned 100/7, result held until accept
        start_op(32'd100, 32'd7, 1'b0, 1'b0);
        check("u100_busy_start", 32'(div_busy_o), 32'd1);
        wait_result("u100_7", 32'd14, 32'd2);
        repeat (3) begin
            @(posedge clk_i);
            #1;
            check("u100_hold_end", 32'(div_end_o), 32'd1);
            check("u100_hold_q", quotient_o, 32'd14);
            check("u100_hold_r", remainder_o, 32'd2);
        end
        do_accept("u100");

        start_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
        wait_result("s_m7_2", 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        do_accept("s_m7_2");

        start_op(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0);
        wait_result("s_7_m2", 32'hFFFF_FFFD, 32'd1);
        do_accept("s_7_m2");

        start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        wait_result("s_ovf", 32'h8000_0000, 32'd0);
        do_accept("s_ovf");

        start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        wait_result("u_big", 32'd0, 32'h8000_0000);
        do_accept("u_big");

        start_op(32'h1234_5678, 32'd0, 1'b1, 1'b0);
        wait_result("s_div0", 32'hFFFF_FFFF, 32'h1234_5678);
        do_accept("s_div0");

        start_op(32'h1234_5678, 32'd0, 1'b0, 1'b0);
        wait_result("u_div0", 32'hFFFF_FFFF, 32'h1234_5678);
        do_accept("u_div0");

        // asynchronous reset between edges, mid-division
        start_op(32'hFFFF_0000, 32'd3, 1'b0, 1'b0);
        repeat (10) @(posedge clk_i);
        #4;
        rst_i = 1'b1;
        #1;
        check("arst_q",    quotient_o, 32'd0);
        check("arst_r",    remainder_o, 32'd0);
        check("arst_end",  32'(div_end_o), 32'd0);
        check("arst_busy", 32'(div_busy_o), 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        end_seen = 1'b0;
        repeat (40) begin
            @(posedge clk_i);
            #1;
            end_seen = end_seen | div_end_o;
        end
        check("arst_no_end", 32'(end_seen), 32'd0);
        start_op(32'd9, 32'd3, 1'b0, 1'b0);
        wait_result("u9_3", 32'd3, 32'd0);
        do_accept("u9_3");

        // back-to-back with start held high across the accept
        start_op(32'd1000, 32'd10, 1'b0, 1'b1);
        wait_result("b2b_first", 32'd100, 32'd0);
        repeat (5) begin
            @(posedge clk_i);
            #1;
            check("b2b_hold_end", 32'(div_end_o), 32'd1);
            check("b2b_hold_q", quotient_o, 32'd100);
            check("b2b_hold_r", remainder_o, 32'd0);
        end
        div_accept_i = 1'b1;
        @(posedge clk_i);
        #1;
        div_accept_i = 1'b0;
        div_opd1_i   = 32'd50;
        div_opd2_i   = 32'd5;
        check("b2b_bubble_end",  32'(div_end_o), 32'd0);
        check("b2b_bubble_busy", 32'(div_busy_o), 32'd0);
        @(posedge clk_i);
        #1;
        div_start_i = 1'b0;
        check("b2b_second_busy", 32'(div_busy_o), 32'd1);
        wait_result("b2b_second", 32'd10, 32'd0);
        do_accept("b2b_second");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
